// File: rtl/riscv_store_buffer.sv
// riscv_store_buffer
//   Posted-write buffer between the core data-memory write port and the
//   memory / MMIO fabric. Stores are captured into an in-order FIFO of DEPTH
//   entries and drained over an OutValid/OutReady handshake. The core is
//   stalled only when the buffer is full.
//
//   Optional feature macro: STORE_FWD_EN
//     defined   -> store-to-load forwarding (youngest matching entry wins)
//     undefined -> FwdHit/FwdData tied to zero, LoadAdr unused
//   The port list is identical in both builds.
module riscv_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         MemWrite,
    input  logic [AW-1:0]                DataAdr,
    input  logic [DW-1:0]                WriteData,
    output logic                         Stall,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic [AW-1:0]                OutAdr,
    output logic [DW-1:0]                OutData,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    input  logic [AW-1:0]                LoadAdr,
    output logic                         FwdHit,
    output logic [DW-1:0]                FwdData
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Storage and bookkeeping state
    logic [AW-1:0]    adr_mem_r [DEPTH];
    logic [DW-1:0]    dat_mem_r [DEPTH];
    logic [DEPTH-1:0] vld_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    // Handshake qualifiers, all derived from registered occupancy
    logic full_s;
    logic empty_s;
    logic enq_s;
    logic deq_s;

    assign full_s  = (count_r == FULL_CNT);
    assign empty_s = (count_r == {CW{1'b0}});
    // A full buffer refuses the store even if the head drains this cycle,
    // which keeps OutReady out of the Stall path.
    assign enq_s   = MemWrite & ~full_s;
    assign deq_s   = ~empty_s & OutReady;

    assign Stall   = MemWrite & full_s;
    assign Count   = count_r;

    // Entry storage, valid bits and pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                adr_mem_r[i] <= {AW{1'b0}};
                dat_mem_r[i] <= {DW{1'b0}};
            end
            vld_r    <= {DEPTH{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (enq_s) begin
                adr_mem_r[wr_ptr_r] <= DataAdr;
                dat_mem_r[wr_ptr_r] <= WriteData;
                vld_r[wr_ptr_r]     <= 1'b1;
                wr_ptr_r            <= wr_ptr_r + PW'(1);
            end
            // When both happen the buffer is neither empty nor full, so the
            // head and tail slots differ and the two valid-bit writes never collide.
            if (deq_s) begin
                vld_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r        <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Occupancy counter: moves only when exactly one side of the FIFO fires
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head entry presented toward memory; zero when nothing is buffered
    always_comb begin
        OutValid = ~empty_s;
        OutAdr   = {AW{1'b0}};
        OutData  = {DW{1'b0}};
        if (!empty_s) begin
            OutAdr  = adr_mem_r[rd_ptr_r];
            OutData = dat_mem_r[rd_ptr_r];
        end else begin
            OutAdr  = {AW{1'b0}};
            OutData = {DW{1'b0}};
        end
    end

`ifdef STORE_FWD_EN
    logic [PW-1:0] fwd_idx_s;
    logic          fwd_hit_s;
    logic [DW-1:0] fwd_data_s;

    // Walk from oldest to youngest so the last match (closest to wr) wins
    always_comb begin
        fwd_idx_s  = {PW{1'b0}};
        fwd_hit_s  = 1'b0;
        fwd_data_s = {DW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_s = rd_ptr_r + PW'(i);
            if (vld_r[fwd_idx_s] && (adr_mem_r[fwd_idx_s] == LoadAdr)) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = dat_mem_r[fwd_idx_s];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    assign FwdHit  = fwd_hit_s;
    assign FwdData = fwd_data_s;
`else
    // Forwarding compiled out: outputs tied low, lookup address and valid
    // bits are intentionally left without a consumer.
    logic unused_fwd_s;
    assign unused_fwd_s = ^{LoadAdr, vld_r};
    assign FwdHit       = 1'b0;
    assign FwdData      = {DW{1'b0}};
`endif

endmodule

// File: tb/tb_riscv_store_buffer.sv
// Testbench for riscv_store_buffer: directed stimulus, drained entries are
// checked by a scoreboard monitor; state is checked directly by the driver.
module tb_riscv_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef STORE_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          MemWrite;
    logic [AW-1:0] DataAdr;
    logic [DW-1:0] WriteData;
    logic          Stall;
    logic          OutValid;
    logic          OutReady;
    logic [AW-1:0] OutAdr;
    logic [DW-1:0] OutData;
    logic [CW-1:0] Count;
    logic [AW-1:0] LoadAdr;
    logic          FwdHit;
    logic [DW-1:0] FwdData;

    int errors = 0;
    int checks = 0;

    logic [AW+DW-1:0] exp_q[$];

    riscv_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .Stall     (Stall),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutAdr    (OutAdr),
        .OutData   (OutData),
        .Count     (Count),
        .LoadAdr   (LoadAdr),
        .FwdHit    (FwdHit),
        .FwdData   (FwdData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; leave the driver 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a store for one cycle; accepted stores are expected downstream
    task automatic store(input logic [AW-1:0] adr, input logic [DW-1:0] dat, input bit accept);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = dat;
        if (accept) exp_q.push_back({adr, dat});
        cyc();
        MemWrite = 1'b0;
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected store
    always @(negedge clk) begin
        if (reset && OutValid && OutReady) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL drain_unexpected: got adr=0x%0h data=0x%0h, nothing expected", OutAdr, OutData);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                if ({OutAdr, OutData} !== e) begin
                    errors++;
                    $display("FAIL drain_order: got adr=0x%0h data=0x%0h expected adr=0x%0h data=0x%0h",
                             OutAdr, OutData, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        MemWrite  = 1'b1;
        DataAdr   = 32'h55;
        WriteData = 32'h1;
        OutReady  = 1'b0;
        LoadAdr   = 32'h0;

        // 1: reset with MemWrite asserted is ignored
        repeat (3) cyc();
        chk("rst_count",   32'(Count), 32'd0);
        chk("rst_valid",   32'(OutValid), 32'd0);
        chk("rst_stall",   32'(Stall), 32'd0);
        chk("rst_outadr",  OutAdr, 32'd0);
        chk("rst_fwdhit",  32'(FwdHit), 32'd0);
        reset    = 1'b1;
        MemWrite = 1'b0;
        repeat (2) cyc();
        chk("post_rst_valid", 32'(OutValid), 32'd0);
        chk("post_rst_count", 32'(Count), 32'd0);

        // 2: two stores held, then drained in order
        store(32'd96, 32'd7, 1'b1);
        chk("one_store_valid", 32'(OutValid), 32'd1);
        store(32'd100, 32'd25, 1'b1);
        chk("two_count",   32'(Count), 32'd2);
        chk("two_outadr",  OutAdr, 32'd96);
        chk("two_outdata", OutData, 32'd7);
        cyc();
        chk("hold_outadr",  OutAdr, 32'd96);
        chk("hold_outdata", OutData, 32'd7);
        OutReady = 1'b1;
        cyc();
        chk("drain1_count",  32'(Count), 32'd1);
        chk("drain1_outadr", OutAdr, 32'd100);
        cyc();
        chk("drain2_count", 32'(Count), 32'd0);
        chk("drain2_valid", 32'(OutValid), 32'd0);
        chk("drain2_outdata", OutData, 32'd0);
        OutReady = 1'b0;

        // 3: fill to DEPTH, overflow store stalls and is not written
        for (int i = 0; i < DEPTH; i++) store(32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1);
        chk("full_count", 32'(Count), 32'd4);
        MemWrite  = 1'b1;
        DataAdr   = 32'h20;
        WriteData = 32'hEE;
        OutReady  = 1'b1;
        #1;
        chk("full_stall", 32'(Stall), 32'd1);
        cyc();
        OutReady = 1'b0;
        chk("after_deq_count", 32'(Count), 32'd3);
        chk("after_deq_stall", 32'(Stall), 32'd0);
        exp_q.push_back({32'h20, 32'hEE});
        cyc();
        MemWrite = 1'b0;
        chk("refill_count", 32'(Count), 32'd4);
        OutReady = 1'b1;
        repeat (4) cyc();
        OutReady = 1'b0;
        chk("full_drain_count", 32'(Count), 32'd0);

        // 4: ten stores across pointer wrap, OutReady every other cycle
        for (int i = 0; i < 10; i++) begin
            store(32'h200 + 32'(4 * i), 32'(3 * i + 1), 1'b1);
            OutReady = 1'b1;
            cyc();
            OutReady = 1'b0;
        end
        chk("wrap_count", 32'(Count), 32'd0);
        chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: simultaneous enqueue and dequeue at Count=2
        store(32'h300, 32'h33, 1'b1);
        store(32'h304, 32'h34, 1'b1);
        chk("simul_pre_count", 32'(Count), 32'd2);
        MemWrite  = 1'b1;
        DataAdr   = 32'h308;
        WriteData = 32'h35;
        OutReady  = 1'b1;
        exp_q.push_back({32'h308, 32'h35});
        cyc();
        MemWrite = 1'b0;
        OutReady = 1'b0;
        chk("simul_count",  32'(Count), 32'd2);
        chk("simul_head",   OutAdr, 32'h304);
        OutReady = 1'b1;
        repeat (2) cyc();
        OutReady = 1'b0;
        chk("simul_drain_count", 32'(Count), 32'd0);

        // 6: forwarding lookup (youngest match wins)
        store(32'd96, 32'd1, 1'b1);
        store(32'd100, 32'd25, 1'b1);
        store(32'd100, 32'd30, 1'b1);
        LoadAdr = 32'd100;
        #1;
        chk("fwd_hit_100",  32'(FwdHit), FWD_ON ? 32'd1 : 32'd0);
        chk("fwd_data_100", FwdData, FWD_ON ? 32'd30 : 32'd0);
        LoadAdr = 32'd96;
        #1;
        chk("fwd_data_96", FwdData, FWD_ON ? 32'd1 : 32'd0);
        LoadAdr   = 32'd104;
        MemWrite  = 1'b1;
        DataAdr   = 32'd104;
        WriteData = 32'd9;
        #1;
        chk("fwd_hit_104_same_cycle", 32'(FwdHit), 32'd0);
        chk("fwd_data_104", FwdData, 32'd0);
        exp_q.push_back({32'd104, 32'd9});
        cyc();
        MemWrite = 1'b0;
        chk("fwd_hit_104_buffered", 32'(FwdHit), FWD_ON ? 32'd1 : 32'd0);
        chk("fwd_data_104_buffered", FwdData, FWD_ON ? 32'd9 : 32'd0);
        OutReady = 1'b1;
        repeat (4) cyc();
        OutReady = 1'b0;
        chk("fwd_after_drain", 32'(FwdHit), 32'd0);

        // 7: reset mid-drain discards pending stores
        store(32'h400, 32'h1, 1'b1);
        store(32'h404, 32'h2, 1'b1);
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_valid", 32'(OutValid), 32'd0);
        chk("midrst_count", 32'(Count), 32'd0);
        cyc();
        reset    = 1'b1;
        OutReady = 1'b1;
        repeat (3) cyc();
        chk("post_midrst_valid", 32'(OutValid), 32'd0);
        OutReady = 1'b0;

        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
